// File: rtl/eu_sequencer.sv
// Execution-unit sequencer: accepts one instruction at a time, drives the external
// combinational ALU from a small register file and writes the result back with flags.
module eu_sequencer #(
    parameter int NREG = 4,
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    output logic [3:0]    alu_opcode,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    input  logic [7:0]    alu_result,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [7:0]    wb_data,
    output logic          flag_z,
    output logic          flag_n,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      op_reg;
    logic [AW-1:0]   rd_reg, rs_reg, rt_reg;
    logic [7:0]      rf_reg  [NREG];
    logic [7:0]      rf_next [NREG];
    logic            wb_valid_reg;
    logic [AW-1:0]   wb_rd_reg;
    logic [7:0]      wb_data_reg;
    logic            flag_z_reg, flag_n_reg;

    logic accept;
    logic wr_en;
    logic ld_ok;

    assign accept = (state_reg == IDLE) && instr_valid;
    assign wr_en  = (state_reg == ISSUE) && (op_reg != 4'b0000);
    // Host loads only land while idle; the instruction write and the load are
    // therefore never active in the same cycle.
    assign ld_ok  = (state_reg == IDLE) && ld_en;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (instr_valid) state_next = ISSUE;
            ISSUE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_opcode = 4'b0000;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        if (state_reg == ISSUE) begin
            alu_opcode = op_reg;
            alu_a      = rf_reg[rs_reg];
            alu_b      = rf_reg[rt_reg];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            assign rf_next[gi] = (wr_en && (rd_reg == AW'(gi))) ? alu_result :
                                 (ld_ok && (ld_addr == AW'(gi))) ? ld_data :
                                 rf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= 8'h00;
            end
        end else begin
            rf_reg <= rf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            op_reg       <= 4'b0000;
            rd_reg       <= '0;
            rs_reg       <= '0;
            rt_reg       <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= 8'h00;
            flag_z_reg   <= 1'b0;
            flag_n_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= wr_en;
            if (accept) begin
                op_reg <= instr_op;
                rd_reg <= instr_rd;
                rs_reg <= instr_rs;
                rt_reg <= instr_rt;
            end
            if (wr_en) begin
                wb_rd_reg   <= rd_reg;
                wb_data_reg <= alu_result;
                flag_z_reg  <= (alu_result == 8'h00);
                flag_n_reg  <= alu_result[7];
            end
        end
    end

    assign instr_ready = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign wb_valid    = wb_valid_reg;
    assign wb_rd       = wb_rd_reg;
    assign wb_data     = wb_data_reg;
    assign flag_z      = flag_z_reg;
    assign flag_n      = flag_n_reg;

endmodule

// File: tb/tb_eu_sequencer.sv
// Self-checking bench for eu_sequencer: a behavioural ALU drives alu_result and a
// register-file model predicts operands, write-backs and flags per instruction.
module tb_eu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = 4'h0;
    logic [1:0] instr_rd = 2'd0, instr_rs = 2'd0, instr_rt = 2'd0;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = 2'd0;
    logic [7:0] ld_data = 8'h00;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       flag_z, flag_n, busy;

    int checks = 0;
    int failures = 0;

    eu_sequencer #(.NREG(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return a & b;
            4'h4: return a | b;
            4'h5: return a ^ b;
            4'h6: return a + 8'd1;
            4'h7: return a - 8'd1;
            4'h8: return ~a;
            4'h9: return {a[6:0], 1'b0};
            4'hA: return {1'b0, a[7:1]};
            4'hB: return {a[7], a[7:1]};
            4'hC: return {a[0], a[7:1]};
            4'hD: return {a[6:0], a[7]};
            4'hE: return a;
            4'hF: return b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_opcode, alu_a, alu_b);

    // Architectural model of the register file and write-back state.
    logic [7:0] m_r [4];
    logic       m_z, m_n;
    logic [1:0] m_wbrd;
    logic [7:0] m_wbd;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_z = 1'b0; m_n = 1'b0; m_wbrd = 2'd0; m_wbd = 8'h00;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        logic [7:0] res;
        if (op != 4'h0) begin
            res = alu_ref(op, m_r[rs], m_r[rt]);
            m_r[rd] = res;
            m_wbrd = rd;
            m_wbd = res;
            m_z = (res == 8'h00);
            m_n = res[7];
        end
    endtask

    typedef struct {
        logic [3:0] op_iss;
        logic [7:0] a_iss, b_iss;
        logic       busy_iss;
        logic       wbv;
        logic [1:0] wbrd;
        logic [7:0] wbd;
        logic       z, n;
        logic [3:0] op_done;
        int         ready_low;
        logic       wbv_after;
        logic       ready_after;
    } obs_t;

    // Host load during an idle cycle.
    task automatic host_load(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
        m_r[addr] = data;
    endtask

    // Drives one instruction through accept/ISSUE/DONE and records what was observed.
    task automatic exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt,
                        input bit ld_acc, input bit ld_iss, input logic [1:0] la, input logic [7:0] ld,
                        output obs_t o);
        o.ready_low = 0;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        if (ld_acc) begin ld_en = 1'b1; ld_addr = la; ld_data = ld; end
        @(negedge clk);
        instr_valid = 1'b0; ld_en = 1'b0;
        instr_op = 4'($urandom); instr_rd = 2'($urandom); instr_rs = 2'($urandom); instr_rt = 2'($urandom);
        o.op_iss = alu_opcode; o.a_iss = alu_a; o.b_iss = alu_b; o.busy_iss = busy;
        if (!instr_ready) o.ready_low++;
        if (ld_iss) begin ld_en = 1'b1; ld_addr = la; ld_data = ld; end
        @(negedge clk);
        ld_en = 1'b0;
        o.wbv = wb_valid; o.wbrd = wb_rd; o.wbd = wb_data; o.z = flag_z; o.n = flag_n; o.op_done = alu_opcode;
        if (!instr_ready) o.ready_low++;
        @(negedge clk);
        o.wbv_after = wb_valid; o.ready_after = instr_ready;
        $display("txn op=%h rd=%0d rs=%0d rt=%0d a=%h b=%h wbv=%0b wb_rd=%0d wb_data=%h z=%0b n=%0b",
                 op, rd, rs, rt, o.a_iss, o.b_iss, o.wbv, o.wbrd, o.wbd, o.z, o.n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({instr_ready, busy, wb_valid, wb_rd, wb_data, flag_z, flag_n} !== {1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b wbv=%b wb_rd=%0d wb_data=%h z=%b n=%b expected 1 0 0 0 00 0 0",
                     instr_ready, busy, wb_valid, wb_rd, wb_data, flag_z, flag_n);
        end
        checks++;
        if ({alu_opcode, alu_a, alu_b} !== 20'h0) begin
            failures++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h expected 0 00 00", alu_opcode, alu_a, alu_b);
        end
    endtask

    task automatic test_add();
        obs_t o;
        host_load(2'd1, 8'h05);
        host_load(2'd2, 8'h03);
        exec(4'h1, 2'd0, 2'd1, 2'd2, 0, 0, 2'd0, 8'h00, o);
        model_exec(4'h1, 2'd0, 2'd1, 2'd2);
        checks++;
        if ({o.op_iss, o.a_iss, o.b_iss, o.busy_iss} !== {4'h1, 8'h05, 8'h03, 1'b1}) begin
            failures++;
            $display("FAIL add_issue: got op=%h a=%h b=%h busy=%b expected 1 05 03 1", o.op_iss, o.a_iss, o.b_iss, o.busy_iss);
        end
        checks++;
        if ({o.wbv, o.wbrd, o.wbd, o.z, o.n} !== {1'b1, 2'd0, 8'h08, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_wb: got wbv=%b rd=%0d data=%h z=%b n=%b expected 1 0 08 0 0", o.wbv, o.wbrd, o.wbd, o.z, o.n);
        end
        checks++;
        if ({o.op_done, o.wbv_after, o.ready_after} !== {4'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_done: got op_done=%h wbv_after=%b ready_after=%b expected 0 0 1", o.op_done, o.wbv_after, o.ready_after);
        end
    endtask

    task automatic test_sub_xor();
        obs_t o;
        exec(4'h2, 2'd3, 2'd2, 2'd1, 0, 0, 2'd0, 8'h00, o);
        model_exec(4'h2, 2'd3, 2'd2, 2'd1);
        checks++;
        if ({o.wbv, o.wbrd, o.wbd, o.z, o.n} !== {1'b1, 2'd3, 8'hFE, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_wb: got wbv=%b rd=%0d data=%h z=%b n=%b expected 1 3 fe 0 1", o.wbv, o.wbrd, o.wbd, o.z, o.n);
        end
        exec(4'h5, 2'd3, 2'd3, 2'd3, 0, 0, 2'd0, 8'h00, o);
        model_exec(4'h5, 2'd3, 2'd3, 2'd3);
        checks++;
        if ({o.wbv, o.wbrd, o.wbd, o.z, o.n} !== {1'b1, 2'd3, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL xor_wb: got wbv=%b rd=%0d data=%h z=%b n=%b expected 1 3 00 1 0", o.wbv, o.wbrd, o.wbd, o.z, o.n);
        end
    endtask

    task automatic test_nop_rol();
        obs_t o;
        host_load(2'd1, 8'h81);
        exec(4'h0, 2'd1, 2'd1, 2'd1, 0, 0, 2'd0, 8'h00, o);
        checks++;
        if ({o.wbv, o.wbrd, o.wbd, o.z, o.n, o.busy_iss} !== {1'b0, m_wbrd, m_wbd, m_z, m_n, 1'b1}) begin
            failures++;
            $display("FAIL nop_state: got wbv=%b rd=%0d data=%h z=%b n=%b busy=%b expected 0 %0d %h %b %b 1",
                     o.wbv, o.wbrd, o.wbd, o.z, o.n, o.busy_iss, m_wbrd, m_wbd, m_z, m_n);
        end
        checks++;
        if (o.ready_low !== 2) begin
            failures++;
            $display("FAIL nop_ready_low: got %0d cycles expected 2", o.ready_low);
        end
        exec(4'hD, 2'd1, 2'd1, 2'd0, 0, 0, 2'd0, 8'h00, o);
        model_exec(4'hD, 2'd1, 2'd1, 2'd0);
        checks++;
        if ({o.wbv, o.wbrd, o.wbd} !== {1'b1, 2'd1, 8'h03}) begin
            failures++;
            $display("FAIL rol_wb: got wbv=%b rd=%0d data=%h expected 1 1 03", o.wbv, o.wbrd, o.wbd);
        end
        checks++;
        if (o.ready_low !== 2) begin
            failures++;
            $display("FAIL rol_ready_low: got %0d cycles expected 2", o.ready_low);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int wbs = 0;
        int acc_cyc [4];
        host_load(2'd0, 8'h00);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'h6; instr_rd = 2'd0; instr_rs = 2'd0; instr_rt = 2'd0;
        for (int c = 0; c < 40 && (acc < 4 || wbs < 4); c++) begin
            if (wb_valid) begin
                checks++;
                if (wb_data !== 8'(wbs + 1)) begin
                    failures++;
                    $display("FAIL b2b_wb_data: got %h expected %h", wb_data, 8'(wbs + 1));
                end
                $display("txn b2b wb_data=%h", wb_data);
                wbs++;
            end
            if (instr_valid && instr_ready) begin
                if (acc < 4) acc_cyc[acc] = c;
                acc++;
            end
            @(negedge clk);
            if (acc >= 4) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        checks++;
        if (acc !== 4 || wbs !== 4) begin
            failures++;
            $display("FAIL b2b_count: got accepts=%0d writebacks=%0d expected 4 4", acc, wbs);
        end
        for (int i = 1; i < 4 && i < acc; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 3) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d cycles expected 3", acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        for (int i = 0; i < 4; i++) model_exec(4'h6, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic test_host_load();
        obs_t o;
        logic [7:0] r2_before;
        r2_before = m_r[2];
        exec(4'hE, 2'd3, 2'd0, 2'd0, 0, 1, 2'd2, 8'hAA, o);
        model_exec(4'hE, 2'd3, 2'd0, 2'd0);
        exec(4'hE, 2'd2, 2'd2, 2'd0, 0, 0, 2'd0, 8'h00, o);
        model_exec(4'hE, 2'd2, 2'd2, 2'd0);
        checks++;
        if (o.wbd !== r2_before) begin
            failures++;
            $display("FAIL load_in_issue_dropped: got R2=%h expected %h", o.wbd, r2_before);
        end
        exec(4'h8, 2'd0, 2'd2, 2'd0, 1, 0, 2'd2, 8'h7F, o);
        m_r[2] = 8'h7F;
        model_exec(4'h8, 2'd0, 2'd2, 2'd0);
        checks++;
        if ({o.a_iss, o.wbd, o.n, o.z} !== {8'h7F, 8'h80, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL load_with_accept: got a=%h data=%h n=%b z=%b expected 7f 80 1 0", o.a_iss, o.wbd, o.n, o.z);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [3:0] op;
        logic [1:0] rd, rs, rt, la;
        logic [7:0] ld, ea, eb;
        bit ld_acc;
        for (int t = 0; t < 40; t++) begin
            op = 4'($urandom); rd = 2'($urandom); rs = 2'($urandom); rt = 2'($urandom);
            la = 2'($urandom); ld = 8'($urandom); ld_acc = ($urandom_range(0, 3) == 0);
            exec(op, rd, rs, rt, ld_acc, 0, la, ld, o);
            if (ld_acc) m_r[la] = ld;
            ea = m_r[rs]; eb = m_r[rt];
            model_exec(op, rd, rs, rt);
            checks++;
            if ({o.op_iss, o.a_iss, o.b_iss} !== {op, ea, eb}) begin
                failures++;
                $display("FAIL rand_issue: got op=%h a=%h b=%h expected %h %h %h", o.op_iss, o.a_iss, o.b_iss, op, ea, eb);
            end
            checks++;
            if ({o.wbv, o.wbrd, o.wbd, o.z, o.n, o.wbv_after} !== {(op != 4'h0), m_wbrd, m_wbd, m_z, m_n, 1'b0}) begin
                failures++;
                $display("FAIL rand_wb: got wbv=%b rd=%0d data=%h z=%b n=%b after=%b expected %b %0d %h %b %b 0",
                         o.wbv, o.wbrd, o.wbd, o.z, o.n, o.wbv_after, (op != 4'h0), m_wbrd, m_wbd, m_z, m_n);
            end
        end
    endtask

    task automatic test_reset_midflight();
        obs_t o;
        host_load(2'd1, 8'h11);
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 4'h1; instr_rd = 2'd0; instr_rs = 2'd1; instr_rt = 2'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({instr_ready, busy, wb_valid, wb_rd, wb_data, flag_z, flag_n, alu_opcode} !==
            {1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL midflight_reset: got rdy=%b busy=%b wbv=%b rd=%0d data=%h z=%b n=%b op=%h expected 1 0 0 0 00 0 0 0",
                     instr_ready, busy, wb_valid, wb_rd, wb_data, flag_z, flag_n, alu_opcode);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_no_wb: got wb_valid=%b expected 0", wb_valid);
        end
        for (int r = 0; r < 4; r++) begin
            exec(4'hE, 2'(r), 2'(r), 2'd0, 0, 0, 2'd0, 8'h00, o);
            model_exec(4'hE, 2'(r), 2'(r), 2'd0);
            checks++;
            if ({o.wbv, o.wbd, o.z} !== {1'b1, m_r[r], 1'b1}) begin
                failures++;
                $display("FAIL midflight_reg%0d: got wbv=%b data=%h z=%b expected 1 %h 1", r, o.wbv, o.wbd, o.z, m_r[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_xor();
        test_nop_rol();
        test_back_to_back();
        test_host_load();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
